wb_data_resize_seq: RTL and testbench

- Sequencing Wishbone width converter: 32-bit master port to 8-bit slave port.
- Splits each master access into one classic 8-bit slave cycle per asserted select bit, in order.
- Gathers read bytes into their 32-bit lanes and returns a single master ack/err/rty per access.
- Sits between the 32-bit intercon and byte-wide peripherals (UART, GPIO, SPI flash) that need full-word or half-word access.

---
 rtl/wb_data_resize_seq_pkg.sv | 23 ++
 rtl/wb_data_resize_seq_if.sv | 25 ++
 rtl/wb_data_resize_seq_sel_next.sv | 29 ++
 rtl/wb_data_resize_seq.sv | 184 ++++++++++++++++++
 tb/tb_wb_data_resize_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_data_resize_seq_pkg.sv
// rtl/wb_data_resize_seq_pkg.sv - shared types for the 32-to-8 bit Wishbone sequencer
// Purpose: FSM state and response encodings plus the offset-to-lane mapping.
// Ports: none (package).
package wb_data_resize_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } resp_t;

  // Byte offset within the word -> physical lane index (sel bit / dat byte).
  function automatic logic [1:0] lane_index(input logic [1:0] off, input bit big_endian);
    return big_endian ? (2'd3 - off) : off;
  endfunction

endpackage

// File: rtl/wb_data_resize_seq_if.sv
// rtl/wb_data_resize_seq_if.sv - classic Wishbone bus bundle, parameterised width
// Purpose: one bus per instance; the converter uses a 32-bit and an 8-bit copy.
// Ports: adr/dat_w/sel/we/cyc/stb/cti/bte (master->slave), dat_r/ack/err/rty (slave->master).
interface wb_data_resize_seq_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0]   adr;
  logic [dw-1:0]   dat_w;
  logic [dw-1:0]   dat_r;
  logic [dw/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte,
                  input  dat_r, ack, err, rty);
  modport slave  (input  adr, dat_w, sel, we, cyc, stb, cti, bte,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_data_resize_seq_sel_next.sv
// rtl/wb_data_resize_seq_sel_next.sv - first remaining byte lane priority encoder
// Purpose: picks the lowest byte offset whose select bit is set.
// Ports: mask (remaining sel bits) in; off (byte offset), lane (one-hot sel bit),
//        last (no other bit remains after this one) out.
module wb_sel_next
  import wb_data_resize_seq_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [3:0] mask,
  output logic [1:0] off,
  output logic [3:0] lane,
  output logic       last
);

  always_comb begin
    off  = 2'd0;
    lane = 4'b0000;
    // Scan from the highest offset down so the lowest selected offset wins.
    for (int o = 3; o >= 0; o--) begin
      if (mask[lane_index(o[1:0], BIG_ENDIAN)]) begin
        off  = o[1:0];
        lane = 4'b0001 << lane_index(o[1:0], BIG_ENDIAN);
      end
    end
    last = ((mask & ~lane) == 4'b0000);
  end

endmodule

// File: rtl/wb_data_resize_seq.sv
// rtl/wb_data_resize_seq.sv - sequencing Wishbone width converter, 32-bit master to 8-bit slave
// Purpose: one classic 8-bit slave cycle per selected byte, gathered into one master response.
// Ports: wb_clk_i clock; wb_rst_i async active-high reset;
//        wbm 32-bit bus (slave modport, faces the intercon);
//        wbs 8-bit bus (master modport, faces the byte-wide peripheral).
module wb_data_resize_seq
  import wb_data_resize_seq_pkg::*;
#(
  parameter int aw         = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  wb_data_resize_seq_if.slave   wbm,
  wb_data_resize_seq_if.master  wbs
);

  state_t         state_q, state_d;
  logic [aw-1:2]  adr_q, adr_d;
  logic           we_q, we_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     mask_q, mask_d;   // lanes still to visit, excluding the current beat
  logic           last_q, last_d;   // current beat is the final one
  logic [1:0]     idx_q, idx_d;     // physical lane of the current beat
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    mdat_q, mdat_d;
  logic           mack_q, mack_d, merr_q, merr_d, mrty_q, mrty_d;
  logic [aw-1:0]  sadr_q, sadr_d;
  logic [7:0]     sdat_q, sdat_d;
  logic           swe_q, swe_d, scyc_q, scyc_d;

  logic [3:0]     enc_mask, enc_lane;
  logic [1:0]     enc_off, enc_idx;
  logic           enc_last;
  logic [31:0]    acc_nx;
  resp_t          rsp;
  logic           unused_inputs;

  // One encoder serves both the first beat (from sel) and every following beat.
  assign enc_mask = (state_q == ST_IDLE) ? wbm.sel : mask_q;
  assign enc_idx  = lane_index(enc_off, BIG_ENDIAN);

  wb_sel_next #(.BIG_ENDIAN(BIG_ENDIAN)) u_sel_next (
    .mask (enc_mask),
    .off  (enc_off),
    .lane (enc_lane),
    .last (enc_last)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    last_d  = last_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    mdat_d  = mdat_q;
    mack_d  = 1'b0;
    merr_d  = 1'b0;
    mrty_d  = 1'b0;
    sadr_d  = sadr_q;
    sdat_d  = sdat_q;
    swe_d   = swe_q;
    scyc_d  = scyc_q;
    acc_nx  = acc_q;
    rsp     = RSP_ACK;

    case (state_q)
      ST_IDLE: begin
        if (wbm.cyc && wbm.stb) begin
          adr_d = wbm.adr[aw-1:2];
          we_d  = wbm.we;
          dat_d = wbm.dat_w;
          acc_d = '0;
          if (wbm.sel == 4'b0000) begin
            state_d = ST_RESP;
            mack_d  = 1'b1;
            mdat_d  = '0;
          end else begin
            state_d = ST_XFER;
            mask_d  = wbm.sel & ~enc_lane;
            last_d  = enc_last;
            idx_d   = enc_idx;
            scyc_d  = 1'b1;
            swe_d   = wbm.we;
            sadr_d  = {wbm.adr[aw-1:2], enc_off};
            sdat_d  = wbm.dat_w[{enc_idx, 3'b000} +: 8];
          end
        end
      end

      ST_XFER: begin
        if (!wbm.cyc) begin
          // Master abort: abandon the slave cycle, ignore whatever it returns.
          state_d = ST_IDLE;
          scyc_d  = 1'b0;
          swe_d   = 1'b0;
        end else if (wbs.err || wbs.rty || wbs.ack) begin
          rsp = wbs.err ? RSP_ERR : (wbs.rty ? RSP_RTY : RSP_ACK);
          if (!we_q) acc_nx[{idx_q, 3'b000} +: 8] = wbs.dat_r;
          if (rsp != RSP_ACK || last_q) begin
            state_d = ST_RESP;
            scyc_d  = 1'b0;
            swe_d   = 1'b0;
            mack_d  = (rsp == RSP_ACK);
            merr_d  = (rsp == RSP_ERR);
            mrty_d  = (rsp == RSP_RTY);
            acc_d   = (rsp == RSP_ACK) ? acc_nx : acc_q;
            mdat_d  = (rsp == RSP_ACK) ? acc_nx : acc_q;
          end else begin
            acc_d  = acc_nx;
            mask_d = mask_q & ~enc_lane;
            last_d = enc_last;
            idx_d  = enc_idx;
            sadr_d = {adr_q, enc_off};
            sdat_d = dat_q[{enc_idx, 3'b000} +: 8];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      mdat_q  <= '0;
      mack_q  <= 1'b0;
      merr_q  <= 1'b0;
      mrty_q  <= 1'b0;
      sadr_q  <= '0;
      sdat_q  <= '0;
      swe_q   <= 1'b0;
      scyc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mdat_q  <= mdat_d;
      mack_q  <= mack_d;
      merr_q  <= merr_d;
      mrty_q  <= mrty_d;
      sadr_q  <= sadr_d;
      sdat_q  <= sdat_d;
      swe_q   <= swe_d;
      scyc_q  <= scyc_d;
    end
  end

  assign wbm.dat_r = mdat_q;
  assign wbm.ack   = mack_q;
  assign wbm.err   = merr_q;
  assign wbm.rty   = mrty_q;

  assign wbs.adr   = sadr_q;
  assign wbs.dat_w = sdat_q;
  assign wbs.sel   = '1;
  assign wbs.we    = swe_q;
  assign wbs.cyc   = scyc_q;
  assign wbs.stb   = scyc_q;
  assign wbs.cti   = 3'b000;
  assign wbs.bte   = 2'b00;

  // Every access is handled as a classic cycle on a word-aligned address.
  assign unused_inputs = ^{wbm.cti, wbm.bte, wbm.adr[1:0]};

endmodule

// File: tb/tb_wb_data_resize_seq.sv
// tb/tb_wb_data_resize_seq.sv - self-checking bench for wb_data_resize_seq
module tb_wb_data_resize_seq;

  localparam int AW = 32;
  localparam bit BE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_data_resize_seq_if #(.aw(AW), .dw(32)) wbm ();
  wb_data_resize_seq_if #(.aw(AW), .dw(8))  wbs ();

  wb_data_resize_seq #(.aw(AW), .BIG_ENDIAN(BE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm      (wbm),
    .wbs      (wbs)
  );

  typedef struct { logic [31:0] adr; logic [7:0] dat; logic we; } beat_t;
  typedef struct { logic [2:0] kind; logic [31:0] dat; logic chk; } resp_s;

  localparam logic [2:0] K_NONE = 3'b000, K_ACK = 3'b001, K_RTY = 3'b010, K_ERR = 3'b100;

  beat_t exp_beats[$];
  resp_s exp_resp[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- byte-wide slave model ----------------
  int         wait_states = 0;
  int         fault_beat  = -1;
  logic [2:0] fault_bits  = 3'b000;   // {err, rty, ack}
  logic [7:0] rd_tab [4];
  int         beat_idx = 0;
  int         wcnt     = 0;

  always_comb begin
    wbs.ack   = 1'b0;
    wbs.err   = 1'b0;
    wbs.rty   = 1'b0;
    wbs.dat_r = rd_tab[beat_idx & 3];
    if (wbs.cyc && wbs.stb && wcnt >= wait_states) begin
      if (beat_idx == fault_beat) {wbs.err, wbs.rty, wbs.ack} = fault_bits;
      else wbs.ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!wbs.cyc) begin
      beat_idx <= 0;
      wcnt     <= 0;
    end else if (wbs.stb && (wbs.ack || wbs.err || wbs.rty)) begin
      beat_idx <= beat_idx + 1;
      wcnt     <= 0;
    end else if (wbs.stb) begin
      wcnt <= wcnt + 1;
    end
  end

  // Slave-side scoreboard: every terminated beat must match the next expected beat.
  always @(negedge clk) begin
    beat_t eb;
    if (wbs.cyc && wbs.stb && (wbs.ack || wbs.err || wbs.rty)) begin
      chk("beat_expected", exp_beats.size() != 0, 1);
      if (exp_beats.size() != 0) begin
        eb = exp_beats.pop_front();
        chk("beat_adr", wbs.adr, eb.adr);
        chk("beat_we", wbs.we, eb.we);
        if (eb.we) chk("beat_dat", wbs.dat_w, eb.dat);
      end
    end
  end

  // Master-side scoreboard: one response per expected access, single-cycle.
  always @(negedge clk) begin
    resp_s er;
    if (wbm.ack || wbm.err || wbm.rty) begin
      chk("resp_expected", exp_resp.size() != 0, 1);
      if (exp_resp.size() != 0) begin
        er = exp_resp.pop_front();
        chk("resp_kind", {wbm.err, wbm.rty, wbm.ack}, er.kind);
        if (er.chk) chk("resp_dat", wbm.dat_r, er.dat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pushes the first n_term beats (offset 0 first) and the master response.
  task automatic expect_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                               input logic we, input int n_term, input logic [2:0] kind);
    int b;
    logic [31:0] ed;
    b  = 0;
    ed = '0;
    for (int o = 0; o < 4; o++) begin
      int p;
      p = BE ? 3 - o : o;
      if (sel[p]) begin
        if (b < n_term) begin
          exp_beats.push_back('{adr: {adr[31:2], o[1:0]}, dat: dat[8*p +: 8], we: we});
          if (!we) ed[8*p +: 8] = rd_tab[b];
        end
        b++;
      end
    end
    if (kind != K_NONE) exp_resp.push_back('{kind: kind, dat: ed, chk: (kind == K_ACK) && !we});
  endtask

  task automatic drive_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic we, output int lat, output logic [31:0] rdat);
    wbm.adr = adr; wbm.dat_w = dat; wbm.sel = sel; wbm.we = we;
    wbm.cti = 3'b010; wbm.bte = 2'b01;
    wbm.cyc = 1'b1; wbm.stb = 1'b1;
    lat  = 0;
    rdat = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (wbm.ack || wbm.err || wbm.rty) begin
        lat  = i;
        rdat = wbm.dat_r;
        break;
      end
    end
    wbm.cyc = 1'b0; wbm.stb = 1'b0;
    chk("resp_within_budget", lat != 0, 1);
    cycles(1);   // let the response cycle finish
  endtask

  task automatic run(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input int n_term, input logic [2:0] kind,
                     output int lat, output logic [31:0] rdat);
    expect_access(adr, dat, sel, we, n_term, kind);
    drive_access(adr, dat, sel, we, lat, rdat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [31:0] rdat;
    wbm.adr = '0; wbm.dat_w = '0; wbm.sel = '0; wbm.we = 1'b0;
    wbm.cyc = 1'b0; wbm.stb = 1'b0; wbm.cti = '0; wbm.bte = '0;
    rd_tab[0] = 8'h55; rd_tab[1] = 8'h66; rd_tab[2] = 8'h77; rd_tab[3] = 8'h88;

    cycles(2);
    chk("rst_wbs_cyc", {wbs.cyc, wbs.stb, wbs.we}, 3'b000);
    chk("rst_wbm_resp", {wbm.ack, wbm.err, wbm.rty}, 3'b000);
    chk("rst_wbs_adr_dat", {wbs.adr, wbs.dat_w}, 40'h0);
    rst = 1'b0;
    cycles(1);

    // Word write, zero-wait slave.
    run(32'h100, 32'hA1B2C3D4, 4'hF, 1'b1, 4, K_ACK, lat, rdat);
    chk("word_write_lat", lat, 5);

    // Half-word read, lanes at offsets 2 and 3.
    run(32'h100, 32'h0, 4'b0011, 1'b0, 2, K_ACK, lat, rdat);
    chk("half_read_lat", lat, 3);
    chk("half_read_dat", rdat, 32'h00005566);

    // Non-contiguous read, two wait states per beat.
    rd_tab[0] = 8'h11; rd_tab[1] = 8'h22;
    wait_states = 2;
    run(32'h100, 32'h0, 4'b1001, 1'b0, 2, K_ACK, lat, rdat);
    chk("sparse_read_lat", lat, 7);
    chk("sparse_read_dat", rdat, 32'h11000022);
    wait_states = 0;

    // Empty select: immediate ack, no slave cycle.
    run(32'h104, 32'hFFFF_FFFF, 4'b0000, 1'b1, 0, K_ACK, lat, rdat);
    chk("sel0_lat", lat, 1);

    // Error / retry on the second beat.
    fault_beat = 1; fault_bits = 3'b100;
    run(32'h180, 32'h01020304, 4'hF, 1'b1, 2, K_ERR, lat, rdat);
    chk("err_lat", lat, 3);
    fault_bits = 3'b010;
    run(32'h184, 32'h05060708, 4'hF, 1'b1, 2, K_RTY, lat, rdat);
    chk("rty_lat", lat, 3);

    // Simultaneous terminations on the first beat: err beats rty beats ack.
    fault_beat = 0; fault_bits = 3'b111;
    run(32'h188, 32'h0, 4'hF, 1'b0, 1, K_ERR, lat, rdat);
    chk("prio_err_lat", lat, 2);
    fault_bits = 3'b011;
    run(32'h18C, 32'h0, 4'hF, 1'b0, 1, K_RTY, lat, rdat);
    chk("prio_rty_lat", lat, 2);
    fault_beat = -1; fault_bits = 3'b000;

    // Master abort during the second beat.
    wait_states = 2;
    expect_access(32'h200, 32'hCAFEF00D, 4'hF, 1'b1, 1, K_NONE);
    wbm.adr = 32'h200; wbm.dat_w = 32'hCAFEF00D; wbm.sel = 4'hF; wbm.we = 1'b1;
    wbm.cyc = 1'b1; wbm.stb = 1'b1;
    cycles(4);
    chk("abort_beat2_active", {wbs.cyc, wbs.adr}, {1'b1, 32'h201});
    chk("abort_cti_bte", {wbs.cti, wbs.bte}, 5'b0);
    wbm.cyc = 1'b0; wbm.stb = 1'b0;
    cycles(1);
    chk("abort_wbs_cyc_low", {wbs.cyc, wbs.stb}, 2'b00);
    cycles(3);
    wait_states = 0;

    rd_tab[0] = 8'hDE; rd_tab[1] = 8'hAD; rd_tab[2] = 8'hBE; rd_tab[3] = 8'hEF;
    run(32'h204, 32'h0, 4'hF, 1'b0, 4, K_ACK, lat, rdat);
    chk("post_abort_lat", lat, 5);
    chk("post_abort_dat", rdat, 32'hDEADBEEF);

    // Reset in the middle of a wait-stated beat.
    wait_states = 2;
    wbm.adr = 32'h300; wbm.dat_w = 32'h12345678; wbm.sel = 4'hF; wbm.we = 1'b1;
    wbm.cyc = 1'b1; wbm.stb = 1'b1;
    cycles(2);
    chk("pre_rst_active", wbs.cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wbs", {wbs.cyc, wbs.stb, wbs.we, wbs.adr, wbs.dat_w}, 43'h0);
    chk("mid_rst_wbm", {wbm.ack, wbm.err, wbm.rty, wbm.dat_r}, 35'h0);
    wbm.cyc = 1'b0; wbm.stb = 1'b0;
    cycles(1);
    rst = 1'b0;
    wait_states = 0;
    cycles(1);

    run(32'h400, 32'h0, 4'b0100, 1'b0, 1, K_ACK, lat, rdat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_dat", rdat, 32'h00DE0000);

    cycles(3);
    chk("beats_left", exp_beats.size(), 0);
    chk("resp_left", exp_resp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
